// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: turns a stream of 32-bit little-endian fetch words into
// a stream of 16-bit (compressed) and 32-bit instructions with their pc.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and ready never looks at the
// downstream ready (fetch_ready_o depends only on buffer fill and flush_i).
//
// Buffer: up to three halfwords hb[0..2]; hb[0] sits at buf_pc. Words are
// only accepted when at most one halfword remains after this cycle's consume,
// so an append of two halfwords can never overflow the three slots.
module rvc_fetch_aligner #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_data_i,
  input  logic [63:0] fetch_pc_i,
  output logic        fetch_ready_o,
  input  logic        flush_i,
  input  logic [63:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic        is_rvc_o,
  input  logic        inst_ready_i
);

  logic [15:0] hb   [0:2];
  logic [15:0] sh   [0:2];
  logic [15:0] hb_n [0:2];
  logic [1:0]  cnt, cnt_c, cnt_n;
  logic [63:0] buf_pc, buf_pc_n;
  logic [63:0] exp_pc, exp_pc_n;
  logic        skip_lo, skip_lo_n;
  logic        head_rvc;
  logic        out_fire;
  logic        fetch_fire;
  logic        fetch_match;

  // The head halfword alone decides the instruction length.
  assign head_rvc      = (hb[0][1:0] != 2'b11);
  assign inst_valid_o  = !flush_i && (((cnt != 2'd0) && head_rvc) || (cnt >= 2'd2));
  assign inst_o        = head_rvc ? {16'h0000, hb[0]} : {hb[1], hb[0]};
  assign pc_o          = buf_pc;
  // Gated by cnt so an empty buffer (including reset) never reports compressed.
  assign is_rvc_o      = (cnt != 2'd0) && head_rvc;
  assign fetch_ready_o = (cnt <= 2'd1) || flush_i;

  assign out_fire    = inst_valid_o && inst_ready_i;
  assign fetch_fire  = fetch_valid_i && fetch_ready_o;
  assign fetch_match = (fetch_pc_i == exp_pc);

  // Consume first: shift out the delivered instruction and advance buf_pc.
  always_comb begin
    sh[0]    = hb[0];
    sh[1]    = hb[1];
    sh[2]    = hb[2];
    cnt_c    = cnt;
    buf_pc_n = buf_pc;
    if (out_fire) begin
      if (head_rvc) begin
        sh[0]    = hb[1];
        sh[1]    = hb[2];
        cnt_c    = cnt - 2'd1;
        buf_pc_n = buf_pc + 64'd2;
      end else begin
        sh[0]    = hb[2];
        cnt_c    = cnt - 2'd2;
        buf_pc_n = buf_pc + 64'd4;
      end
    end
  end

  // Then append the accepted word behind what remains; flush overrides all.
  always_comb begin
    hb_n[0]   = sh[0];
    hb_n[1]   = sh[1];
    hb_n[2]   = sh[2];
    cnt_n     = cnt_c;
    exp_pc_n  = exp_pc;
    skip_lo_n = skip_lo;
    if (flush_i) begin
      hb_n[0]   = hb[0];
      hb_n[1]   = hb[1];
      hb_n[2]   = hb[2];
      cnt_n     = 2'd0;
      exp_pc_n  = {redirect_pc_i[63:2], 2'b00};
      skip_lo_n = redirect_pc_i[1];
    end else if (fetch_fire && fetch_match) begin
      exp_pc_n = exp_pc + 64'd4;
      if (skip_lo) begin
        // Redirect landed on the upper halfword: drop the lower one.
        case (cnt_c)
          2'd0:    hb_n[0] = fetch_data_i[31:16];
          2'd1:    hb_n[1] = fetch_data_i[31:16];
          default: hb_n[2] = fetch_data_i[31:16];
        endcase
        cnt_n     = cnt_c + 2'd1;
        skip_lo_n = 1'b0;
      end else begin
        case (cnt_c)
          2'd0: begin
            hb_n[0] = fetch_data_i[15:0];
            hb_n[1] = fetch_data_i[31:16];
          end
          default: begin
            hb_n[1] = fetch_data_i[15:0];
            hb_n[2] = fetch_data_i[31:16];
          end
        endcase
        cnt_n = cnt_c + 2'd2;
      end
    end
  end

  // State register; reset empties the buffer immediately (asynchronous).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb[0]   <= 16'h0000;
      hb[1]   <= 16'h0000;
      hb[2]   <= 16'h0000;
      cnt     <= 2'd0;
      buf_pc  <= RESET_PC;
      exp_pc  <= RESET_PC;
      skip_lo <= 1'b0;
    end else begin
      hb[0]   <= hb_n[0];
      hb[1]   <= hb_n[1];
      hb[2]   <= hb_n[2];
      cnt     <= cnt_n;
      buf_pc  <= flush_i ? redirect_pc_i : buf_pc_n;
      exp_pc  <= exp_pc_n;
      skip_lo <= skip_lo_n;
    end
  end

endmodule

// File: doc/rvc_fetch_aligner.md
RVC_FETCH_ALIGNER -- requirements
Module: rvc_fetch_aligner

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the first fetch address after reset and SHALL be 4-byte aligned.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 fetch_valid_i  input  1  a fetched word is offered.
REQ-005 fetch_data_i  input  32  fetched word, little-endian; the low halfword is the lower address.
REQ-006 fetch_pc_i  input  64  word address of fetch_data_i, with bits [1:0] equal to 0.
REQ-007 fetch_ready_o  output  1  the aligner accepts the offered word this cycle.
REQ-008 flush_i  input  1  redirect request.
REQ-009 redirect_pc_i  input  64  new pc, 2-byte aligned.
REQ-010 inst_valid_o  output  1  an instruction is presented.
REQ-011 inst_o  output  32  raw instruction; for a 16-bit instruction, bits [31:16] SHALL be 0. This feeds the expander inst_i.
REQ-012 pc_o  output  64  address of inst_o; feeds the expander pc_i.
REQ-013 is_rvc_o  output  1  set when inst_o[1:0] != 2'b11.
REQ-014 inst_ready_i  input  1  the consumer takes the instruction this cycle.

Function
REQ-015 The state SHALL be:
- buffer hb[0..2] of 16-bit halfwords;
- cnt (0..3), the number of valid halfwords;
- buf_pc, the address of hb[0];
- exp_pc, the next expected word address;
- skip_lo, a flag that discards the low halfword of the next accepted word.
REQ-016 fetch_ready_o SHALL be (cnt <= 1) OR flush_i, and SHALL not depend on inst_ready_i.
REQ-017 A fetch handshake SHALL occur when fetch_valid_i and fetch_ready_o are both high.
REQ-018 An accepted word with fetch_pc_i != exp_pc SHALL be discarded without any state change (stale response).
REQ-019 An accepted word with fetch_pc_i == exp_pc SHALL advance exp_pc by 4 and append halfwords at index cnt_after_consume:
- both halfwords, low first, when skip_lo is 0;
- only the high halfword, with skip_lo then cleared, when skip_lo is 1.
REQ-020 inst_valid_o SHALL be high when flush_i is 0 and either:
- cnt >= 1 and hb[0][1:0] != 2'b11; or
- cnt >= 2.
REQ-021 Output values:
- compressed: inst_o = {16'h0, hb[0]};
- otherwise: inst_o = {hb[1], hb[0]};
- pc_o = buf_pc in both cases.
REQ-022 On an output handshake (inst_valid_o and inst_ready_i both high), the aligner SHALL consume 1 halfword (compressed) or 2 halfwords, shift the remaining halfwords down, and advance buf_pc by 2 or 4 respectively.
REQ-023 Consume and append in the same cycle SHALL both take effect, with the consume applied first; cnt SHALL never exceed 3 and SHALL never underflow.
REQ-024 When inst_valid_o is high and inst_ready_i is low, inst_o, pc_o and is_rvc_o SHALL hold stable.
REQ-025 On flush_i, the next state SHALL be:
- cnt = 0;
- buf_pc = redirect_pc_i;
- exp_pc = {redirect_pc_i[63:2], 2'b00};
- skip_lo = redirect_pc_i[1].
REQ-026 flush_i SHALL have priority over a simultaneous fetch or output handshake: any offered word is accepted and dropped, and the instruction is not delivered.
REQ-027 A 32-bit instruction split across two words SHALL be presented only once its upper halfword has arrived.
REQ-028 exp_pc and buf_pc SHALL wrap modulo 2^64 without any error indication.

Reset
REQ-029 While rst is high, the state SHALL be cnt = 0, skip_lo = 0, buf_pc = RESET_PC, exp_pc = RESET_PC and hb = 0.
REQ-030 While rst is high, the outputs SHALL be inst_valid_o = 0, inst_o = 0, pc_o = RESET_PC, is_rvc_o = 0 and fetch_ready_o = 1.
REQ-031 Assertion of rst mid-operation SHALL discard buffered halfwords immediately, without waiting for a clock edge.
REQ-032 Normal operation SHALL resume on the first rising edge of clk after rst deasserts.

Verification
REQ-033 Two compressed instructions: word 0x4501_4081 @0x80000000 with ready=1 -> 0x00004081 @0x80000000 rvc=1, then 0x00004501 @0x80000002 rvc=1.
REQ-034 Aligned 32-bit instruction: word 0x00000013 @0x80000000 -> 0x00000013 @0x80000000 rvc=0 in one instruction.
REQ-035 Split 32-bit instruction: words 0x0013_4081 @0x80000000 then 0x1234_0000 @0x80000004 -> in order:
- 0x00004081 @0x80000000;
- 0x00000013 @0x80000002, not presented before the second word arrives;
- 0x00001234 @0x80000006 rvc=1.
REQ-036 Redirect: flush_i with redirect_pc_i = 0x80000102, then stale word @0x80000008 (dropped), then 0x4501_FFFF @0x80000100 -> only 0x00004501 @0x80000102.
REQ-037 Backpressure: inst_ready_i = 0, three 16-bit halfwords buffered (cnt = 3) -> fetch_ready_o = 0 and outputs stable for 10 cycles; raising inst_ready_i resumes the stream with no loss or duplication.
REQ-038 Async reset: assert rst mid-cycle with cnt = 2 -> inst_valid_o = 0 and pc_o = 0x80000000 before the next clk edge.
